hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Stall/forward controller for the 5-stage MIPS pipeline (F/D/E/M/W).
- Consumes the per-instruction register-timing record produced for the D-stage instruction: r_new, t_new, r_use1/2, t_use1/2.
- Keeps a scoreboard of those records for the E/M/W stages.
- Drives the global D-stage stall, the E-stage bubble, and every forwarding-mux select.

Parameters:
- MULT_CYCLES, 5, busy cycles after a multiply issues (used only with MDU_STALL_EN).
- DIV_CYCLES, 10, busy cycles after a divide issues (used only with MDU_STALL_EN).

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- d_r_use1  in  5  first source register of the D instruction (0 = none)
- d_r_use2  in  5  second source register of the D instruction (0 = none)
- d_t_use1  in  2  cycles from D until d_r_use1 is consumed
- d_t_use2  in  2  cycles from D until d_r_use2 is consumed
- d_r_new  in  5  destination register of the D instruction (0 = none)
- d_t_new  in  2  cycles from D until the result exists (0..3)
- d_md_op  in  2  00 none, 01 mult, 10 div, 11 reserved (treated as none); MDU_STALL_EN only
- d_md_use  in  1  D instruction reads or writes HI/LO or starts the MDU; MDU_STALL_EN only
- stall  out  1  hold PC and the F/D register; insert a bubble into E
- fwd_d1  out  2  D operand 1 source: 0 regfile, 1 E, 2 M, 3 W
- fwd_d2  out  2  D operand 2 source: 0 regfile, 1 E, 2 M, 3 W
- fwd_e1  out  2  E operand 1 source: 0 pipeline register, 1 M, 2 W
- fwd_e2  out  2  E operand 2 source: 0 pipeline register, 1 M, 2 W
- fwd_m2  out  1  M store data source: 0 pipeline register, 1 W

Behaviour:
- Scoreboard registers per stage:
  - E: r_new, t_new, r_use1, r_use2
  - M: r_new, t_new, r_use2
  - W: r_new
  - Reset clears all of them to 0. With all stages empty, every output is 0.
- Advance on every clk edge (there is no external freeze):
  - E <= D record with t_new = sat(d_t_new - 1). If stall=1, E <= bubble (all fields 0) instead.
  - M <= E with t_new = sat(E.t_new - 1).
  - W <= M.r_new.
  - sat clamps at 0.
- Stall is combinational, same cycle. For each i in {1,2} with d_r_use_i != 0, stall when either holds:
  - E.r_new == d_r_use_i and E.t_new > d_t_use_i
  - M.r_new == d_r_use_i and M.t_new > d_t_use_i
- Register $0 never matches, so it never stalls or forwards.
- D forwarding (fwd_d_i), priority youngest first:
  - 1 if E.r_new matches and E.t_new == 0
  - else 2 if M.r_new matches and M.t_new == 0
  - else 3 if W.r_new matches
  - else 0
  - A younger match that is not ready blocks older sources: select stays 0 and stall covers it.
- E forwarding (fwd_e_i) on E.r_use_i:
  - 1 if M matches and M.t_new == 0
  - else 2 if W matches
  - else 0
- fwd_m2 = 1 when M.r_use2 != 0 and M.r_use2 == W.r_new.
- The regfile does not bypass its own write, so W forwarding is always required.
- Reset asserted mid-stall: next cycle the scoreboard is empty and stall drops unless MDU busy re-asserts it (it cannot, because the counter is also cleared).

Optional Feature:
- Macro: MDU_STALL_EN.
- With the macro defined:
  - The E record also carries md_op.
  - A 4-bit busy counter loads MULT_CYCLES or DIV_CYCLES when E holds md_op 01 or 10, and decrements to 0 otherwise.
  - stall is additionally asserted when d_md_use=1 and (counter != 0 or E.md_op is 01/10).
  - Reset clears the counter.
- Without the macro: d_md_op and d_md_use are ignored, and the counter logic is absent.

Test Plan:
- addu $3 in E (d_t_new=2), then beq using $3 (t_use=0) -> stall=1 for 1 cycle, then fwd_d1=2 (from M).
- lw $5 (t_new=3), then addu using $5 (t_use=1) -> stall=1 for exactly 1 cycle; next cycle stall=0, fwd_e1=2 (from W).
- ori $4, then sw storing $4 (t_use2=2) -> no stall; sw E-stage fwd_e2=1 (from M).
- Two writers of $7 in E and M, both t_new=0, reader in D -> fwd_d1=1 (E wins); with r_use=$0 -> fwd_d1=0, stall=0.
- Reset asserted while lw is in E and stall=1 -> next cycle stall=0 and all fwd_* = 0.
- MDU_STALL_EN: div issues, then mflo in D -> stall held 11 cycles (1 with div in E + 10 counter), then released; without the macro -> stall=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall / forwarding controller for the 5-stage MIPS pipeline.
// Tracks the register-timing record (r_new/t_new/r_use) of the instructions
// in E, M and W and derives the D-stage stall, the E bubble and every
// forwarding-mux select from it.
// Optional feature macro: MDU_STALL_EN adds a multiply/divide busy counter
// that stalls HI/LO users while the MDU is working.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] d_r_use1,
  input  logic [4:0] d_r_use2,
  input  logic [1:0] d_t_use1,
  input  logic [1:0] d_t_use2,
  input  logic [4:0] d_r_new,
  input  logic [1:0] d_t_new,
  input  logic [1:0] d_md_op,
  input  logic       d_md_use,
  output logic       stall,
  output logic [1:0] fwd_d1,
  output logic [1:0] fwd_d2,
  output logic [1:0] fwd_e1,
  output logic [1:0] fwd_e2,
  output logic       fwd_m2
);

  // D forwarding select encodings
  localparam logic [1:0] FD_RF = 2'd0;
  localparam logic [1:0] FD_E  = 2'd1;
  localparam logic [1:0] FD_M  = 2'd2;
  localparam logic [1:0] FD_W  = 2'd3;

  // E forwarding select encodings
  localparam logic [1:0] FE_PR = 2'd0;
  localparam logic [1:0] FE_M  = 2'd1;
  localparam logic [1:0] FE_W  = 2'd2;

  // Scoreboard: E stage record
  logic [4:0] e_r_new_q,  e_r_new_d;
  logic [1:0] e_t_new_q,  e_t_new_d;
  logic [4:0] e_r_use1_q, e_r_use1_d;
  logic [4:0] e_r_use2_q, e_r_use2_d;

  // Scoreboard: M stage record
  logic [4:0] m_r_new_q,  m_r_new_d;
  logic [1:0] m_t_new_q,  m_t_new_d;
  logic [4:0] m_r_use2_q, m_r_use2_d;

  // Scoreboard: W stage record
  logic [4:0] w_r_new_q,  w_r_new_d;

  // Per-operand hazard terms
  logic       hz_d1;
  logic       hz_d2;
  logic       mdu_stall;

  // Saturating decrement of a stage timing field (clamps at 0).
  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : (t - 2'd1);
  endfunction

  // Register match that can never hit on $0.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  // A D operand must wait if a younger producer will not have its result
  // by the time the operand is consumed.
  function automatic logic src_hazard(
    input logic [4:0] r_use,
    input logic [1:0] t_use,
    input logic [4:0] e_rn,
    input logic [1:0] e_tn,
    input logic [4:0] m_rn,
    input logic [1:0] m_tn
  );
    logic e_hit;
    logic m_hit;
    e_hit = reg_match(r_use, e_rn) && (e_tn > t_use);
    m_hit = reg_match(r_use, m_rn) && (m_tn > t_use);
    return e_hit || m_hit;
  endfunction

  // D-stage source select, youngest producer first. A younger match that is
  // not ready yet blocks older sources; the stall takes care of that case.
  function automatic logic [1:0] d_select(
    input logic [4:0] r_use,
    input logic [4:0] e_rn,
    input logic [1:0] e_tn,
    input logic [4:0] m_rn,
    input logic [1:0] m_tn,
    input logic [4:0] w_rn
  );
    logic [1:0] sel;
    sel = FD_RF;
    if (reg_match(r_use, e_rn)) begin
      sel = (e_tn == 2'd0) ? FD_E : FD_RF;
    end else if (reg_match(r_use, m_rn)) begin
      sel = (m_tn == 2'd0) ? FD_M : FD_RF;
    end else if (reg_match(r_use, w_rn)) begin
      sel = FD_W;
    end
    return sel;
  endfunction

  // E-stage source select: M if its result is ready, else W on a match.
  function automatic logic [1:0] e_select(
    input logic [4:0] r_use,
    input logic [4:0] m_rn,
    input logic [1:0] m_tn,
    input logic [4:0] w_rn
  );
    logic [1:0] sel;
    sel = FE_PR;
    if (reg_match(r_use, m_rn) && (m_tn == 2'd0)) begin
      sel = FE_M;
    end else if (reg_match(r_use, w_rn)) begin
      sel = FE_W;
    end
    return sel;
  endfunction

  // Data hazards for the two D-stage operands.
  always_comb begin
    hz_d1 = src_hazard(d_r_use1, d_t_use1, e_r_new_q, e_t_new_q, m_r_new_q, m_t_new_q);
    hz_d2 = src_hazard(d_r_use2, d_t_use2, e_r_new_q, e_t_new_q, m_r_new_q, m_t_new_q);
  end

  assign stall = hz_d1 | hz_d2 | mdu_stall;

  // Forwarding selects derived from the current scoreboard.
  always_comb begin
    fwd_d1 = d_select(d_r_use1, e_r_new_q, e_t_new_q, m_r_new_q, m_t_new_q, w_r_new_q);
    fwd_d2 = d_select(d_r_use2, e_r_new_q, e_t_new_q, m_r_new_q, m_t_new_q, w_r_new_q);
    fwd_e1 = e_select(e_r_use1_q, m_r_new_q, m_t_new_q, w_r_new_q);
    fwd_e2 = e_select(e_r_use2_q, m_r_new_q, m_t_new_q, w_r_new_q);
    fwd_m2 = reg_match(m_r_use2_q, w_r_new_q);
  end

  // Next scoreboard contents: D enters E (or a bubble on stall), E moves to
  // M and M to W, with the remaining-time fields counting down.
  always_comb begin
    e_r_new_d  = d_r_new;
    e_t_new_d  = dec_sat(d_t_new);
    e_r_use1_d = d_r_use1;
    e_r_use2_d = d_r_use2;
    if (stall) begin
      e_r_new_d  = 5'd0;
      e_t_new_d  = 2'd0;
      e_r_use1_d = 5'd0;
      e_r_use2_d = 5'd0;
    end
    m_r_new_d  = e_r_new_q;
    m_t_new_d  = dec_sat(e_t_new_q);
    m_r_use2_d = e_r_use2_q;
    w_r_new_d  = m_r_new_q;
  end

  // Scoreboard registers; synchronous reset empties every stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_r_new_q  <= 5'd0;
      e_t_new_q  <= 2'd0;
      e_r_use1_q <= 5'd0;
      e_r_use2_q <= 5'd0;
      m_r_new_q  <= 5'd0;
      m_t_new_q  <= 2'd0;
      m_r_use2_q <= 5'd0;
      w_r_new_q  <= 5'd0;
    end else begin
      e_r_new_q  <= e_r_new_d;
      e_t_new_q  <= e_t_new_d;
      e_r_use1_q <= e_r_use1_d;
      e_r_use2_q <= e_r_use2_d;
      m_r_new_q  <= m_r_new_d;
      m_t_new_q  <= m_t_new_d;
      m_r_use2_q <= m_r_use2_d;
      w_r_new_q  <= w_r_new_d;
    end
  end

`ifdef MDU_STALL_EN
  localparam logic [1:0] MD_MULT = 2'b01;
  localparam logic [1:0] MD_DIV  = 2'b10;

  logic [1:0] e_md_op_q, e_md_op_d;
  logic [3:0] busy_q,    busy_d;
  logic       e_md_start;

  // A multiply or divide sitting in E is about to start the unit.
  assign e_md_start = (e_md_op_q == MD_MULT) || (e_md_op_q == MD_DIV);

  // HI/LO users wait while an operation is starting or still in flight.
  assign mdu_stall = d_md_use && ((busy_q != 4'd0) || e_md_start);

  // Next md_op for E and next busy count.
  always_comb begin
    e_md_op_d = stall ? 2'b00 : d_md_op;
    busy_d    = (busy_q == 4'd0) ? 4'd0 : (busy_q - 4'd1);
    if (e_md_op_q == MD_MULT) begin
      busy_d = 4'(MULT_CYCLES);
    end else if (e_md_op_q == MD_DIV) begin
      busy_d = 4'(DIV_CYCLES);
    end
  end

  // MDU op tracking and busy counter; cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_md_op_q <= 2'b00;
      busy_q    <= 4'd0;
    end else begin
      e_md_op_q <= e_md_op_d;
      busy_q    <= busy_d;
    end
  end
`else
  // Without the MDU tracker the HI/LO inputs and cycle counts have no effect.
  logic [3:0] unused_mdu;
  assign unused_mdu = {d_md_op, d_md_use, 1'b0} ^ 4'(MULT_CYCLES) ^ 4'(DIV_CYCLES);
  assign mdu_stall  = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed bench for hazard_ctrl. Inputs change on the
// falling edge; outputs are checked 1 ns later, i.e. before the next rising
// edge that captures the driven D record.
module tb_hazard_ctrl;

  // Clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] d_r_use1, d_r_use2, d_r_new;
  logic [1:0] d_t_use1, d_t_use2, d_t_new, d_md_op;
  logic       d_md_use;
  logic       stall;
  logic [1:0] fwd_d1, fwd_d2, fwd_e1, fwd_e2;
  logic       fwd_m2;

  int checks = 0;
  int errors = 0;

  hazard_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .d_r_use1 (d_r_use1),
    .d_r_use2 (d_r_use2),
    .d_t_use1 (d_t_use1),
    .d_t_use2 (d_t_use2),
    .d_r_new  (d_r_new),
    .d_t_new  (d_t_new),
    .d_md_op  (d_md_op),
    .d_md_use (d_md_use),
    .stall    (stall),
    .fwd_d1   (fwd_d1),
    .fwd_d2   (fwd_d2),
    .fwd_e1   (fwd_e1),
    .fwd_e2   (fwd_e2),
    .fwd_m2   (fwd_m2)
  );

  // Driver: present a D record on the falling edge, settle 1 ns.
  task automatic drv_md(input logic [4:0] ru1, input logic [4:0] ru2,
                        input logic [1:0] tu1, input logic [1:0] tu2,
                        input logic [4:0] rn,  input logic [1:0] tn,
                        input logic [1:0] mop, input logic muse);
    @(negedge clk);
    d_r_use1 = ru1;
    d_r_use2 = ru2;
    d_t_use1 = tu1;
    d_t_use2 = tu2;
    d_r_new  = rn;
    d_t_new  = tn;
    d_md_op  = mop;
    d_md_use = muse;
    #1;
  endtask

  task automatic drv(input logic [4:0] ru1, input logic [4:0] ru2,
                     input logic [1:0] tu1, input logic [1:0] tu2,
                     input logic [4:0] rn,  input logic [1:0] tn);
    drv_md(ru1, ru2, tu1, tu2, rn, tn, 2'b00, 1'b0);
  endtask

  // Keep the current D record for one more cycle.
  task automatic hold();
    @(negedge clk);
    #1;
  endtask

  // Fill every stage with no-ops.
  task automatic flush();
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    hold();
    hold();
  endtask

  // Single comparison point.
  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic s,
                         input logic [1:0] d1, input logic [1:0] d2,
                         input logic [1:0] e1, input logic [1:0] e2,
                         input logic m2);
    chk({tag, ".stall"},  {1'b0, stall},  {1'b0, s});
    chk({tag, ".fwd_d1"}, fwd_d1, d1);
    chk({tag, ".fwd_d2"}, fwd_d2, d2);
    chk({tag, ".fwd_e1"}, fwd_e1, e1);
    chk({tag, ".fwd_e2"}, fwd_e2, e2);
    chk({tag, ".fwd_m2"}, {1'b0, fwd_m2}, {1'b0, m2});
  endtask

  initial begin
    // Reset with an idle D stage
    reset    = 1'b1;
    d_r_use1 = 5'd0;
    d_r_use2 = 5'd0;
    d_t_use1 = 2'd0;
    d_t_use2 = 2'd0;
    d_r_new  = 5'd0;
    d_t_new  = 2'd0;
    d_md_op  = 2'b00;
    d_md_use = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk_all("reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    reset = 1'b0;

    // addu $3,$1,$2 then beq $3,$0: one stall, then forward from M
    drv(5'd1, 5'd2, 2'd1, 2'd1, 5'd3, 2'd2);
    chk_all("addu_d", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drv(5'd3, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    chk_all("beq_stall", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    hold();
    chk_all("beq_fwd_m", 1'b0, 2'd2, 2'd0, 2'd0, 2'd0, 1'b0);
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    chk_all("beq_e_from_w", 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0);
    flush();

    // lw $5 then addu $8,$5,$9: exactly one stall, then E forwards from W
    drv(5'd6, 5'd0, 2'd1, 2'd0, 5'd5, 2'd3);
    chk_all("lw_d", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drv(5'd5, 5'd9, 2'd1, 2'd1, 5'd8, 2'd2);
    chk_all("lw_use_stall", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    hold();
    chk_all("lw_use_release", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    chk_all("lw_use_fwd_e", 1'b0, 2'd0, 2'd0, 2'd2, 2'd0, 1'b0);
    flush();

    // ori $4 then sw $4: no stall, E store data from M, then M from W
    drv(5'd1, 5'd0, 2'd1, 2'd0, 5'd4, 2'd2);
    drv(5'd2, 5'd4, 2'd1, 2'd2, 5'd0, 2'd0);
    chk_all("sw_d", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    chk_all("sw_e", 1'b0, 2'd0, 2'd0, 2'd0, 2'd1, 1'b0);
    hold();
    chk_all("sw_m", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1);
    flush();

    // Two ready writers of $7 in E and M: E wins
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd7, 2'd1);
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd7, 2'd1);
    drv(5'd7, 5'd7, 2'd0, 2'd0, 5'd0, 2'd0);
    chk_all("two_writers", 1'b0, 2'd1, 2'd1, 2'd0, 2'd0, 1'b0);
    flush();

    // $0 never stalls or forwards
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd3);
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    chk_all("zero_reg_e", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    hold();
    chk_all("zero_reg_m", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    flush();

    // Writer of $10 reaches W: D forwards from W
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd10, 2'd1);
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd0, 2'd0);
    drv(5'd10, 5'd0, 2'd1, 2'd0, 5'd0, 2'd0);
    chk_all("w_fwd_d", 1'b0, 2'd3, 2'd0, 2'd0, 2'd0, 1'b0);
    flush();

    // Not-ready E producer of $11 blocks the ready M copy (late consumer)
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd11, 2'd1);
    drv(5'd0, 5'd0, 2'd0, 2'd0, 5'd11, 2'd3);
    drv(5'd11, 5'd0, 2'd3, 2'd0, 5'd0, 2'd0);
    chk_all("young_block", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    flush();

    // Reset while lw is in E and the dependent addu stalls
    drv(5'd6, 5'd0, 2'd1, 2'd0, 5'd5, 2'd3);
    drv(5'd5, 5'd9, 2'd1, 2'd1, 5'd8, 2'd2);
    chk_all("pre_reset_stall", 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    reset = 1'b1;
    hold();
    chk_all("mid_stall_reset", 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 1'b0);
    reset = 1'b0;
    flush();

    // div then mflo
    drv_md(5'd1, 5'd2, 2'd1, 2'd1, 5'd0, 2'd0, 2'b10, 1'b1);
    chk("div_d.stall", {1'b0, stall}, 2'd0);
    drv_md(5'd0, 5'd0, 2'd0, 2'd0, 5'd3, 2'd2, 2'b00, 1'b1);
`ifdef MDU_STALL_EN
    for (int c = 0; c < 11; c++) begin
      if (c > 0) hold();
      chk($sformatf("mflo_busy%0d.stall", c), {1'b0, stall}, 2'd1);
    end
    hold();
    chk("mflo_release.stall", {1'b0, stall}, 2'd0);
`else
    chk("mflo_no_mdu.stall", {1'b0, stall}, 2'd0);
    hold();
    chk("mflo_no_mdu_next.stall", {1'b0, stall}, 2'd0);
`endif
    flush();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
